sd_boot_loader: RTL and testbench

//  Downstream consumer of the SD-card SPI engine after card init completes (spi_initdone).

---
 rtl/sd_boot_pkg.sv | 35 +++
 rtl/sd_ldr_timeout.sv | 31 +++
 rtl/sd_boot_loader.sv | 237 +++++++++++++++++++++++
 tb/tb_sd_boot_loader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_boot_pkg.sv
// Shared definitions for the SD-card boot loader: FSM states, CMD17 frame
// bytes, SPI engine flag bit positions and loader error codes.
package sd_boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_R1,
        ST_RECV,
        ST_NEXT,
        ST_DONE,
        ST_ERROR
    } ldr_state_t;

    // Command byte is start bit 0, transmission bit 1, then the 6-bit index
    localparam logic [5:0] CMD17_INDEX = 6'd17;
    localparam logic [7:0] CMD17_BYTE  = {2'b01, CMD17_INDEX};
    localparam logic [7:0] FRAME_CRC   = 8'hFF;

    localparam int FLG_WORD = 0;
    localparam int FLG_R1   = 1;
    localparam int FLG_END  = 2;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_BAD_R1   = 3'd1;
    localparam logic [2:0] ERR_SHORT    = 3'd2;
    localparam logic [2:0] ERR_LONG     = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd4;
    localparam logic [2:0] ERR_CHECKSUM = 3'd5;

    function automatic logic [47:0] cmd17_frame(input logic [31:0] lba);
        return {CMD17_BYTE, lba, FRAME_CRC};
    endfunction

endpackage

// File: rtl/sd_ldr_timeout.sv
// Loadable down-counter used as the loader's wait watchdog. expire is high
// while enabled and the count has reached zero.
module sd_ldr_timeout #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] cnt;

    // Load has priority over counting so an arriving event restarts the window
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && (cnt != '0))
            cnt <= cnt - 1'b1;
    end

    assign expire = en && (cnt == '0);

endmodule

// File: rtl/sd_boot_loader.sv
// SD-card boot loader: reads NUM_BLOCKS blocks via CMD17 and writes the
// returned words into boot RAM, holding the CPU in reset until done.
// Optional feature macro: LDR_CHECKSUM_EN (final word checks the word sum).
module sd_boot_loader
    import sd_boot_pkg::*;
#(
    parameter int          NUM_BLOCKS      = 8,
    parameter int          WORDS_PER_BLOCK = 128,
    parameter logic [31:0] START_LBA       = 32'd0,
    parameter int          MEM_AW          = 10,
    parameter int          TIMEOUT_CYC     = 65535,
    parameter int          MAX_RETRY       = 3
) (
    input  logic              spi_clk_i,
    input  logic              spi_rst_i,
    input  logic              spi_initdone_i,
    input  logic              ldr_start_i,
    input  logic [31:0]       spi_data_i,
    input  logic [2:0]        spi_flagreg_i,
    input  logic [7:0]        R1,
    output logic [47:0]       spi_cmd_o,
    output logic [7:0]        spi_statusreg_o,
    output logic              mem_we_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [31:0]       mem_data_o,
    output logic              ldr_busy_o,
    output logic              ldr_done_o,
    output logic              ldr_error_o,
    output logic [2:0]        ldr_errcode_o,
    output logic [31:0]       ldr_checksum_o,
    output logic              cpu_rst_o
);

    localparam int WC_W  = $clog2(WORDS_PER_BLOCK) + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int BLK_W = 8;
    localparam int RT_W  = $clog2(MAX_RETRY + 2);

    if (NUM_BLOCKS < 1 || NUM_BLOCKS > 256) begin : g_blk_range
        $error("NUM_BLOCKS must be in 1..256");
    end
    if (NUM_BLOCKS * WORDS_PER_BLOCK > 2 ** MEM_AW) begin : g_mem_fit
        $error("boot image does not fit in RAM address space");
    end

    ldr_state_t        state;
    logic              start_pend;
    logic [BLK_W-1:0]  blk;
    logic [WC_W-1:0]   wcnt;
    logic [WC_W-1:0]   wcnt_nx;
    logic              drop;
    logic              drop_nx;
    logic [RT_W-1:0]   retry;
    logic [MEM_AW-1:0] waddr;
    logic              word_vld, r1_vld, end_vld;
    logic              word_take, last_blk, final_word;
    logic              to_expire;
    logic              err_hit;
    logic [2:0]        err_code;

    assign word_vld = spi_flagreg_i[FLG_WORD];
    assign r1_vld   = spi_flagreg_i[FLG_R1];
    assign end_vld  = spi_flagreg_i[FLG_END];

`ifdef LDR_CHECKSUM_EN
    logic [31:0] csum;
    logic        csum_bad;

    function automatic logic [31:0] csum_add(input logic [31:0] a, input logic [31:0] b);
        return a + b;
    endfunction

    assign ldr_checksum_o = csum;
`else
    assign ldr_checksum_o = 32'd0;
`endif

    // Word bookkeeping: a word arriving with block_end is counted before the end check
    always_comb begin
        word_take  = (state == ST_RECV) && word_vld && (wcnt < WC_W'(WORDS_PER_BLOCK));
        wcnt_nx    = word_take ? wcnt + 1'b1 : wcnt;
        drop_nx    = drop | ((state == ST_RECV) && word_vld && !word_take);
        last_blk   = (blk == BLK_W'(NUM_BLOCKS - 1));
        final_word = word_take && last_blk && (wcnt == WC_W'(WORDS_PER_BLOCK - 1));
        waddr      = MEM_AW'(int'(blk) * WORDS_PER_BLOCK + int'(wcnt));
    end

    // Terminal error detection for the current cycle
    always_comb begin
        err_hit  = 1'b0;
        err_code = ERR_NONE;
        case (state)
            ST_WAIT_R1: begin
                if (retry == RT_W'(MAX_RETRY)) begin
                    if (r1_vld && (R1 != 8'h00)) begin
                        err_hit  = 1'b1;
                        err_code = ERR_BAD_R1;
                    end else if (!r1_vld && to_expire) begin
                        err_hit  = 1'b1;
                        err_code = ERR_TIMEOUT;
                    end
                end
            end
            ST_RECV: begin
                if (end_vld) begin
                    if (drop_nx) begin
                        err_hit  = 1'b1;
                        err_code = ERR_LONG;
                    end else if (wcnt_nx < WC_W'(WORDS_PER_BLOCK)) begin
                        err_hit  = 1'b1;
                        err_code = ERR_SHORT;
                    end
                end else if (!word_vld && to_expire) begin
                    err_hit  = 1'b1;
                    err_code = ERR_TIMEOUT;
                end
            end
`ifdef LDR_CHECKSUM_EN
            ST_NEXT: begin
                if (last_blk && csum_bad) begin
                    err_hit  = 1'b1;
                    err_code = ERR_CHECKSUM;
                end
            end
`endif
            default: ;
        endcase
    end

    sd_ldr_timeout #(.CNT_W(TO_W)) u_timeout (
        .clk      (spi_clk_i),
        .rst      (spi_rst_i),
        .clr      ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR)),
        .load     ((state == ST_ISSUE) || ((state == ST_WAIT_R1) && r1_vld) ||
                   ((state == ST_RECV) && word_vld)),
        .en       ((state == ST_WAIT_R1) || (state == ST_RECV)),
        .load_val (TO_W'(TIMEOUT_CYC)),
        .expire   (to_expire)
    );

    // Loader FSM with registered command, RAM-write and status outputs
    always_ff @(posedge spi_clk_i or posedge spi_rst_i) begin
        if (spi_rst_i) begin
            state           <= ST_IDLE;
            start_pend      <= 1'b0;
            blk             <= '0;
            wcnt            <= '0;
            drop            <= 1'b0;
            retry           <= '0;
            spi_cmd_o       <= '0;
            spi_statusreg_o <= '0;
            mem_we_o        <= 1'b0;
            mem_addr_o      <= '0;
            mem_data_o      <= '0;
            ldr_busy_o      <= 1'b0;
            ldr_done_o      <= 1'b0;
            ldr_error_o     <= 1'b0;
            ldr_errcode_o   <= ERR_NONE;
            cpu_rst_o       <= 1'b1;
`ifdef LDR_CHECKSUM_EN
            csum            <= '0;
            csum_bad        <= 1'b0;
`endif
        end else begin
            spi_statusreg_o <= 8'h00;
            mem_we_o        <= 1'b0;
            if (state == ST_RECV) begin
                wcnt <= wcnt_nx;
                drop <= drop_nx;
                if (word_take) begin
                    mem_we_o   <= 1'b1;
                    mem_addr_o <= waddr;
                    mem_data_o <= spi_data_i;
                end
`ifdef LDR_CHECKSUM_EN
                if (final_word)
                    csum_bad <= (spi_data_i != csum);
                else if (word_take)
                    csum <= csum_add(csum, spi_data_i);
`endif
            end
            if (err_hit) begin
                state         <= ST_ERROR;
                ldr_error_o   <= 1'b1;
                ldr_errcode_o <= err_code;
                ldr_busy_o    <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if ((start_pend || ldr_start_i) && spi_initdone_i) begin
                            start_pend <= 1'b0;
                            blk        <= '0;
                            retry      <= '0;
                            ldr_busy_o <= 1'b1;
                            state      <= ST_ISSUE;
                        end else if (ldr_start_i) begin
                            start_pend <= 1'b1;
                        end
                    end
                    ST_ISSUE: begin
                        spi_cmd_o       <= cmd17_frame(START_LBA + 32'(blk));
                        spi_statusreg_o <= 8'h01;
                        wcnt            <= '0;
                        drop            <= 1'b0;
                        state           <= ST_WAIT_R1;
                    end
                    ST_WAIT_R1: begin
                        if (r1_vld && (R1 == 8'h00)) begin
                            state <= ST_RECV;
                        end else if (r1_vld || to_expire) begin
                            retry <= retry + 1'b1;
                            state <= ST_ISSUE;
                        end
                    end
                    ST_RECV: begin
                        if (end_vld)
                            state <= ST_NEXT;
                    end
                    ST_NEXT: begin
                        if (last_blk) begin
                            state      <= ST_DONE;
                            ldr_done_o <= 1'b1;
                            cpu_rst_o  <= 1'b0;
                            ldr_busy_o <= 1'b0;
                        end else begin
                            blk   <= blk + 1'b1;
                            retry <= '0;
                            state <= ST_ISSUE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sd_boot_loader.sv
// Directed testbench for sd_boot_loader (2 blocks x 4 words, 32-cycle timeout).
module tb_sd_boot_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        initdone;
    logic        start;
    logic [31:0] sdata;
    logic [2:0]  flags;
    logic [7:0]  r1;
    logic [47:0] spi_cmd;
    logic [7:0]  status;
    logic        mem_we;
    logic [3:0]  mem_addr;
    logic [31:0] mem_data;
    logic        busy, done, err, cpu_rst;
    logic [2:0]  errcode;
    logic [31:0] checksum;

    int tests = 0;
    int fails = 0;
    int cmd_cnt = 0;
    int c0;

    always #5 clk = ~clk;

    sd_boot_loader #(
        .NUM_BLOCKS(2), .WORDS_PER_BLOCK(4), .START_LBA(32'd0),
        .MEM_AW(4), .TIMEOUT_CYC(32), .MAX_RETRY(3)
    ) dut (
        .spi_clk_i(clk), .spi_rst_i(rst), .spi_initdone_i(initdone),
        .ldr_start_i(start), .spi_data_i(sdata), .spi_flagreg_i(flags), .R1(r1),
        .spi_cmd_o(spi_cmd), .spi_statusreg_o(status),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_data_o(mem_data),
        .ldr_busy_o(busy), .ldr_done_o(done), .ldr_error_o(err),
        .ldr_errcode_o(errcode), .ldr_checksum_o(checksum), .cpu_rst_o(cpu_rst)
    );

    always @(posedge clk) begin
        if (status[0])
            cmd_cnt <= cmd_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cmd"}, spi_cmd, 48'h0);
        chk({tag, "_status"}, status, 8'h00);
        chk({tag, "_we"}, mem_we, 1'b0);
        chk({tag, "_addr"}, mem_addr, 4'h0);
        chk({tag, "_data"}, mem_data, 32'h0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_err"}, err, 1'b0);
        chk({tag, "_code"}, errcode, 3'd0);
        chk({tag, "_csum"}, checksum, 32'h0);
        chk({tag, "_cpu_rst"}, cpu_rst, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1; flags = 3'b000; start = 1'b0; r1 = 8'h00; sdata = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_cmd(input string tag, input logic [31:0] lba);
        int n = 0;
        while (!status[0] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_go"}, status, 8'h01);
        chk({tag, "_frame"}, spi_cmd, {8'h51, lba, 8'hFF});
    endtask

    task automatic send_r1(input logic [7:0] v);
        flags = 3'b010; r1 = v;
        @(negedge clk);
        flags = 3'b000; r1 = 8'h00;
    endtask

    task automatic send_word(input logic [31:0] d, input int exp_addr, input logic exp_we,
                             input logic with_end);
        sdata = d;
        flags = with_end ? 3'b101 : 3'b001;
        @(negedge clk);
        flags = 3'b000;
        chk($sformatf("wr%0d_we", exp_addr), mem_we, exp_we);
        if (exp_we) begin
            chk($sformatf("wr%0d_addr", exp_addr), mem_addr, 4'(exp_addr));
            chk($sformatf("wr%0d_data", exp_addr), mem_data, d);
        end
    endtask

    task automatic send_end();
        flags = 3'b100;
        @(negedge clk);
        flags = 3'b000;
    endtask

    task automatic run_block(input int b, input logic [31:0] d0, input logic [31:0] dlast);
        wait_cmd($sformatf("cmd_blk%0d", b), 32'(b));
        send_r1(8'h00);
        for (int i = 0; i < 3; i++)
            send_word(d0 + 32'(i), b * 4 + i, 1'b1, 1'b0);
        send_word(dlast, b * 4 + 3, 1'b1, 1'b0);
        send_end();
    endtask

    task automatic check_final(input string tag, input logic e_done, input logic e_err,
                               input logic [2:0] e_code, input logic e_cpu);
        repeat (3) @(negedge clk);
        chk({tag, "_done"}, done, e_done);
        chk({tag, "_err"}, err, e_err);
        chk({tag, "_code"}, errcode, e_code);
        chk({tag, "_cpu_rst"}, cpu_rst, e_cpu);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        initdone = 1'b0;
        do_reset();
        check_reset_vals("rst");

        // Happy path: words 1..7 then 28 (also a valid checksum image)
        initdone = 1'b1;
        c0 = cmd_cnt;
        pulse_start();
        chk("t1_busy", busy, 1'b1);
        run_block(0, 32'd1, 32'd4);
        run_block(1, 32'd5, 32'd28);
        check_final("t1", 1'b1, 1'b0, 3'd0, 1'b0);
        chk("t1_ncmd", 64'(cmd_cnt - c0), 64'd2);
`ifdef LDR_CHECKSUM_EN
        chk("t1_csum", checksum, 32'd28);
`else
        chk("t1_csum", checksum, 32'd0);
`endif
        pulse_start();
        repeat (5) @(negedge clk);
        chk("t1_restart_ignored", 64'(cmd_cnt - c0), 64'd2);

        // One bad R1 then a good one
        do_reset();
        c0 = cmd_cnt;
        pulse_start();
        wait_cmd("t2a_try0", 32'd0);
        send_r1(8'h05);
        run_block(0, 32'd1, 32'd4);
        run_block(1, 32'd5, 32'd28);
        check_final("t2a", 1'b1, 1'b0, 3'd0, 1'b0);
        chk("t2a_ncmd", 64'(cmd_cnt - c0), 64'd3);

        // Four bad R1 in a row exhaust the retries
        do_reset();
        c0 = cmd_cnt;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            wait_cmd($sformatf("t2b_try%0d", i), 32'd0);
            send_r1(8'h05);
        end
        check_final("t2b", 1'b0, 1'b1, 3'd1, 1'b1);
        chk("t2b_ncmd", 64'(cmd_cnt - c0), 64'd4);

        // Start before initdone is latched; short block
        initdone = 1'b0;
        do_reset();
        c0 = cmd_cnt;
        pulse_start();
        repeat (5) @(negedge clk);
        chk("t3a_no_cmd_yet", 64'(cmd_cnt - c0), 64'd0);
        initdone = 1'b1;
        wait_cmd("t3a_cmd", 32'd0);
        send_r1(8'h00);
        for (int i = 0; i < 3; i++)
            send_word(32'h10 + 32'(i), i, 1'b1, 1'b0);
        send_end();
        check_final("t3a", 1'b0, 1'b1, 3'd2, 1'b1);

        // Long block: fifth word dropped without a write
        do_reset();
        pulse_start();
        wait_cmd("t3b_cmd", 32'd0);
        send_r1(8'h00);
        for (int i = 0; i < 4; i++)
            send_word(32'h20 + 32'(i), i, 1'b1, 1'b0);
        send_word(32'h24, 4, 1'b0, 1'b0);
        send_end();
        check_final("t3b", 1'b0, 1'b1, 3'd3, 1'b1);

        // Word gap in RECV: alive at 30 cycles, timed out after 40
        do_reset();
        pulse_start();
        wait_cmd("t4a_cmd", 32'd0);
        send_r1(8'h00);
        send_word(32'h30, 0, 1'b1, 1'b0);
        send_word(32'h31, 1, 1'b1, 1'b0);
        repeat (30) @(negedge clk);
        chk("t4a_alive_err", err, 1'b0);
        chk("t4a_alive_busy", busy, 1'b1);
        repeat (10) @(negedge clk);
        chk("t4a_err", err, 1'b1);
        chk("t4a_code", errcode, 3'd4);
        chk("t4a_cpu_rst", cpu_rst, 1'b1);

        // Fourth word coincident with block_end is accepted
        do_reset();
        pulse_start();
        wait_cmd("t4b_cmd", 32'd0);
        send_r1(8'h00);
        for (int i = 0; i < 3; i++)
            send_word(32'd1 + 32'(i), i, 1'b1, 1'b0);
        send_word(32'd4, 3, 1'b1, 1'b1);
        run_block(1, 32'd5, 32'd28);
        check_final("t4b", 1'b1, 1'b0, 3'd0, 1'b0);

        // Reset mid-load, then a clean reload from LBA 0 / addr 0
        do_reset();
        pulse_start();
        wait_cmd("t5_cmd", 32'd0);
        send_r1(8'h00);
        send_word(32'h50, 0, 1'b1, 1'b0);
        send_word(32'h51, 1, 1'b1, 1'b0);
        #1 rst = 1'b1;
        #1;
        check_reset_vals("t5_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pulse_start();
        run_block(0, 32'd1, 32'd4);
        run_block(1, 32'd5, 32'd28);
        check_final("t5", 1'b1, 1'b0, 3'd0, 1'b0);

`ifdef LDR_CHECKSUM_EN
        // Wrong final checksum word
        do_reset();
        pulse_start();
        run_block(0, 32'd1, 32'd4);
        run_block(1, 32'd5, 32'd29);
        check_final("t6", 1'b0, 1'b1, 3'd5, 1'b1);
        chk("t6_csum", checksum, 32'd28);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
